// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, error pulses and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered dout.
module fifo_sync_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AFULL_THR  = DEPTH - 2,
    parameter int unsigned AEMPTY_THR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_n,
    input  logic                       rd_n,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          rd_acc;
    logic          wr_acc;

    // Flush suppresses both accepts and error pulses; a read frees the slot a full-FIFO write needs.
    always_comb begin
        rd_acc = !flush && !rd_n && !empty_q;
        wr_acc = !flush && !wr_n && (!full_q || rd_acc);
        ovf_d  = !flush && !wr_n && full_q && !rd_acc;
        unf_d  = !flush && !rd_n && empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AFULL_THR));
        aempty_d = (count_d <= CW'(AEMPTY_THR));
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    assign dout = mem_q[rd_ptr_q];
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
            dout_d = mem_q[rd_ptr_q];
        end
    end

    // Flush leaves dout alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (DEPTH=8, AFULL_THR=6, AEMPTY_THR=2).
// Data-output checks follow the build: registered dout by default, FWFT when FIFO_FWFT_EN is defined.
module tb_fifo_sync_param;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int unsigned n_total;
    int unsigned n_bad;

    fifo_sync_param #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AFULL_THR (6),
        .AEMPTY_THR(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_n        (wr_n),
        .rd_n        (rd_n),
        .din         (din),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_aempty"}, int'(almost_empty), 1);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_afull"}, int'(almost_full), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_unf"}, int'(underflow), 0);
`ifndef FIFO_FWFT_EN
        check({tag, "_dout"}, int'(dout), 0);
`endif
    endtask

    // Pops one word and checks it against exp in whichever read mode is built.
    task automatic pop_check(input string tag, input int unsigned exp);
`ifdef FIFO_FWFT_EN
        check(tag, int'(dout), exp);
`endif
        rd_n = 1'b0;
        step();
        rd_n = 1'b1;
`ifndef FIFO_FWFT_EN
        check(tag, int'(dout), exp);
`endif
    endtask

    task automatic push(input int unsigned val);
        wr_n = 1'b0;
        din  = 8'(val);
        step();
        wr_n = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        din     = '0;
        idle();

        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst");

        // Fill 1..8 with flag tracking, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            push(i);
            check("fill_count", int'(count), i);
            check("fill_afull", int'(almost_full), int'(i >= 6));
            check("fill_aempty", int'(almost_empty), int'(i <= 2));
            check("fill_full", int'(full), int'(i == 8));
            check("fill_empty", int'(empty), 0);
        end
        for (int i = 1; i <= 8; i++) begin
            pop_check("drain_dout", i);
            check("drain_count", int'(count), 8 - i);
            check("drain_empty", int'(empty), int'(i == 8));
        end

        // Overflow on a full FIFO leaves contents intact.
        for (int i = 1; i <= 8; i++) push(i);
        wr_n = 1'b0;
        din  = 8'hEE;
        step();
        wr_n = 1'b1;
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_count", int'(count), 8);
        step();
        check("ovf_clear", int'(overflow), 0);
        pop_check("ovf_head", 8'h01);
        for (int i = 2; i <= 8; i++) pop_check("ovf_rest", i);
        check("ovf_empty", int'(empty), 1);

        // Read+write on empty: write lands, underflow pulses.
        wr_n = 1'b0;
        rd_n = 1'b0;
        din  = 8'hA5;
        step();
        idle();
        check("unf_pulse", int'(underflow), 1);
        check("unf_count", int'(count), 1);
        pop_check("unf_data", 8'hA5);
        check("unf_clear", int'(underflow), 0);
        check("unf_count0", int'(count), 0);

        // Full-FIFO streaming across pointer wrap.
        for (int i = 0; i < 8; i++) push(8'h20 + i);
        for (int k = 0; k < 20; k++) begin
`ifdef FIFO_FWFT_EN
            check("stream_dout", int'(dout), 8'h20 + k);
`endif
            wr_n = 1'b0;
            rd_n = 1'b0;
            din  = 8'(8'h28 + k);
            step();
`ifndef FIFO_FWFT_EN
            check("stream_dout", int'(dout), 8'h20 + k);
`endif
            check("stream_count", int'(count), 8);
            check("stream_ovf", int'(overflow), 0);
            check("stream_unf", int'(underflow), 0);
        end
        idle();
        for (int j = 0; j < 8; j++) pop_check("stream_tail", 8'h34 + j);

        // Flush at count 5 with a concurrent write.
        for (int i = 0; i < 5; i++) push(8'h40 + i);
        check("pre_flush_count", int'(count), 5);
        flush = 1'b1;
        wr_n  = 1'b0;
        din   = 8'h99;
        step();
        idle();
        check("flush_count", int'(count), 0);
        check("flush_empty", int'(empty), 1);
        check("flush_aempty", int'(almost_empty), 1);
        check("flush_ovf", int'(overflow), 0);
        check("flush_full", int'(full), 0);
`ifndef FIFO_FWFT_EN
        check("flush_dout_hold", int'(dout), 8'h3B);
`endif
        push(8'h55);
        pop_check("post_flush", 8'h55);

        // Reset mid-burst at count 3.
        for (int i = 0; i < 3; i++) push(8'h61 + i);
        check("pre_rst_count", int'(count), 3);
        wr_n = 1'b0;
        rd_n = 1'b0;
        din  = 8'h77;
        rst  = 1'b1;
        step();
        idle();
        check_reset_state("midrst");
        push(8'h88);
        check("post_rst_count", int'(count), 1);
        pop_check("post_rst_data", 8'h88);

`ifdef FIFO_FWFT_EN
        // Head word is visible without a read.
        push(8'h3C);
        check("fwft_head", int'(dout), 8'h3C);
        check("fwft_nonempty", int'(empty), 0);
        rd_n = 1'b0;
        step();
        rd_n = 1'b1;
        check("fwft_empty", int'(empty), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
